// File: rtl/gate_sweep_driver_if.sv
`default_nettype none
// ============================================================================
//  Module      : gate_sweep_driver_if
//  Description : Bundle between the gate sweep driver and the lab top level /
//                gate-under-test. master = the sweep driver, slave = the
//                environment that supplies start/op_sel and the DUT outputs.
//  Signals     : start, op_sel[1:0]        run request, expected function
//                dut_out, dut_out_always   the two outputs of the gate DUT
//                drv_in1, drv_in2          stimulus onto the gate DUT
//                busy, done, pass          run status
//                err_count[ERR_W-1:0]      saturating mismatch count
//                err_mask[1:0]             sticky per-output error flags
//  Revision    : 1.0 - initial release
// ============================================================================
interface gate_sweep_driver_if #(
    parameter int ERR_W = 8
);
    logic             start;
    logic [1:0]       op_sel;
    logic             dut_out;
    logic             dut_out_always;
    logic             drv_in1;
    logic             drv_in2;
    logic             busy;
    logic             done;
    logic             pass;
    logic [ERR_W-1:0] err_count;
    logic [1:0]       err_mask;

    modport master (
        input  start, op_sel, dut_out, dut_out_always,
        output drv_in1, drv_in2, busy, done, pass, err_count, err_mask
    );

    modport slave (
        output start, op_sel, dut_out, dut_out_always,
        input  drv_in1, drv_in2, busy, done, pass, err_count, err_mask
    );
endinterface
`default_nettype wire

// File: rtl/gate_sweep_driver.sv
`default_nettype none
// ============================================================================
//  Module      : gate_sweep_driver
//  Description : Sweeps the four input vectors onto a 2-input gate DUT, holds
//                each for SETTLE_CYCLES, samples both DUT outputs, compares
//                against the selected function and reports the result.
//  Ports       : clk    - system clock
//                rst_n  - asynchronous active-low reset
//                bus    - gate_sweep_driver_if.master (handshake, DUT
//                         stimulus/response, status and error reporting)
//  Revision    : 1.0 - initial release
// ============================================================================
module gate_sweep_driver #(
    parameter int SETTLE_CYCLES = 2,   // 1..15
    parameter int NUM_PASSES    = 1,   // 1..255
    parameter int ERR_W         = 8
) (
    input  wire logic            clk,
    input  wire logic            rst_n,
    gate_sweep_driver_if.master  bus
);

    localparam int               c_sum_w       = ERR_W + 1;
    localparam logic [ERR_W-1:0] c_err_max     = '1;
    localparam logic [3:0]       c_settle_last = 4'(SETTLE_CYCLES - 1);
    localparam logic [7:0]       c_pass_last   = 8'(NUM_PASSES - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DRIVE  = 2'd1,
        S_SAMPLE = 2'd2,
        S_FINISH = 2'd3
    } state_t;

    state_t           r_state,    w_state_nxt;
    logic [1:0]       r_op,       w_op_nxt;
    logic [1:0]       r_vec,      w_vec_nxt;
    logic [7:0]       r_pass_cnt, w_pass_cnt_nxt;
    logic [3:0]       r_settle,   w_settle_nxt;
    logic [1:0]       r_drv,      w_drv_nxt;
    logic             r_busy,     w_busy_nxt;
    logic             r_done,     w_done_nxt;
    logic             r_pass,     w_pass_nxt;
    logic [ERR_W-1:0] r_err_cnt,  w_err_cnt_nxt;
    logic [1:0]       r_err_mask, w_err_mask_nxt;

    logic             w_expected;
    logic             w_mis_c;
    logic             w_mis_a;
    logic [c_sum_w-1:0] w_err_sum;
    logic [ERR_W-1:0] w_err_sat;

    // Expected gate response for the vector currently on the DUT inputs.
    always_comb begin
        w_expected = 1'b0;
        case (r_op)
            2'd0:    w_expected =   r_drv[1] & r_drv[0];
            2'd1:    w_expected =   r_drv[1] | r_drv[0];
            2'd2:    w_expected =   r_drv[1] ^ r_drv[0];
            default: w_expected = ~(r_drv[1] & r_drv[0]);
        endcase
    end

    assign w_mis_c   = (bus.dut_out        != w_expected);
    assign w_mis_a   = (bus.dut_out_always != w_expected);
    // One extra bit of headroom so a two-error step past the top is detected.
    assign w_err_sum = {1'b0, r_err_cnt} + c_sum_w'(w_mis_c) + c_sum_w'(w_mis_a);
    assign w_err_sat = (w_err_sum > {1'b0, c_err_max}) ? c_err_max
                                                        : w_err_sum[ERR_W-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_op       <= 2'd0;
            r_vec      <= 2'd0;
            r_pass_cnt <= 8'd0;
            r_settle   <= 4'd0;
            r_drv      <= 2'd0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_pass     <= 1'b0;
            r_err_cnt  <= '0;
            r_err_mask <= 2'd0;
        end else begin
            r_state    <= w_state_nxt;
            r_op       <= w_op_nxt;
            r_vec      <= w_vec_nxt;
            r_pass_cnt <= w_pass_cnt_nxt;
            r_settle   <= w_settle_nxt;
            r_drv      <= w_drv_nxt;
            r_busy     <= w_busy_nxt;
            r_done     <= w_done_nxt;
            r_pass     <= w_pass_nxt;
            r_err_cnt  <= w_err_cnt_nxt;
            r_err_mask <= w_err_mask_nxt;
        end
    end

    // Status flags are registered from the next state, so busy/done line up
    // exactly with the DRIVE/SAMPLE and FINISH cycles.
    always_comb begin
        w_state_nxt    = r_state;
        w_op_nxt       = r_op;
        w_vec_nxt      = r_vec;
        w_pass_cnt_nxt = r_pass_cnt;
        w_settle_nxt   = r_settle;
        w_drv_nxt      = r_drv;
        w_busy_nxt     = r_busy;
        w_done_nxt     = 1'b0;
        w_pass_nxt     = r_pass;
        w_err_cnt_nxt  = r_err_cnt;
        w_err_mask_nxt = r_err_mask;

        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_op_nxt       = bus.op_sel;
                    w_err_cnt_nxt  = '0;
                    w_err_mask_nxt = 2'd0;
                    w_pass_nxt     = 1'b0;
                    w_vec_nxt      = 2'd0;
                    w_pass_cnt_nxt = 8'd0;
                    w_settle_nxt   = 4'd0;
                    w_drv_nxt      = 2'd0;
                    w_busy_nxt     = 1'b1;
                    w_state_nxt    = S_DRIVE;
                end
            end
            S_DRIVE: begin
                if (r_settle == c_settle_last) begin
                    w_state_nxt = S_SAMPLE;
                end else begin
                    w_settle_nxt = r_settle + 4'd1;
                end
            end
            S_SAMPLE: begin
                w_err_cnt_nxt  = w_err_sat;
                w_err_mask_nxt = r_err_mask | {w_mis_a, w_mis_c};
                w_settle_nxt   = 4'd0;
                if (r_vec != 2'd3) begin
                    w_vec_nxt   = r_vec + 2'd1;
                    w_drv_nxt   = r_vec + 2'd1;
                    w_state_nxt = S_DRIVE;
                end else if (r_pass_cnt != c_pass_last) begin
                    w_vec_nxt      = 2'd0;
                    w_drv_nxt      = 2'd0;
                    w_pass_cnt_nxt = r_pass_cnt + 8'd1;
                    w_state_nxt    = S_DRIVE;
                end else begin
                    w_drv_nxt   = 2'd0;
                    w_busy_nxt  = 1'b0;
                    w_done_nxt  = 1'b1;
                    // Judged on the mask including this final sample.
                    w_pass_nxt  = ((r_err_mask | {w_mis_a, w_mis_c}) == 2'b00);
                    w_state_nxt = S_FINISH;
                end
            end
            default: begin
                // FINISH: start is deliberately not examined here.
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign bus.drv_in1   = r_drv[1];
    assign bus.drv_in2   = r_drv[0];
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.pass      = r_pass;
    assign bus.err_count = r_err_cnt;
    assign bus.err_mask  = r_err_mask;

endmodule
`default_nettype wire

// File: tb/tb_gate_sweep_driver.sv
`default_nettype none
// ============================================================================
//  Module      : tb_gate_sweep_driver
//  Description : Self-checking bench for gate_sweep_driver. Two instances:
//                u0 defaults (SETTLE=2, PASSES=1, ERR_W=8) and u1 (SETTLE=1,
//                PASSES=2, ERR_W=2). A behavioural gate DUT with optional
//                faults answers both; a run-level model predicts the results.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_gate_sweep_driver;

    logic clk;
    logic rst_n;
    logic cur;                 // which instance the current run targets
    logic [1:0] dut_fn;        // function the simulated gate really computes
    logic [1:0] fault_c;       // 0 none, 1 stuck0, 2 stuck1, 3 inverted
    logic [1:0] fault_a;
    int n_tests;
    int n_fail;

    gate_sweep_driver_if #(.ERR_W(8)) if0 ();
    gate_sweep_driver_if #(.ERR_W(2)) if1 ();

    gate_sweep_driver #(.SETTLE_CYCLES(2), .NUM_PASSES(1), .ERR_W(8)) u0 (
        .clk(clk), .rst_n(rst_n), .bus(if0)
    );
    gate_sweep_driver #(.SETTLE_CYCLES(1), .NUM_PASSES(2), .ERR_W(2)) u1 (
        .clk(clk), .rst_n(rst_n), .bus(if1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic gate_f(input logic [1:0] fn, input logic a, input logic b);
        case (fn)
            2'd0:    return a & b;
            2'd1:    return a | b;
            2'd2:    return a ^ b;
            default: return ~(a & b);
        endcase
    endfunction

    function automatic logic dut_val(input logic [1:0] fn, input logic [1:0] flt,
                                     input logic a, input logic b);
        case (flt)
            2'd0:    return gate_f(fn, a, b);
            2'd1:    return 1'b0;
            2'd2:    return 1'b1;
            default: return ~gate_f(fn, a, b);
        endcase
    endfunction

    assign if0.dut_out        = dut_val(dut_fn, fault_c, if0.drv_in1, if0.drv_in2);
    assign if0.dut_out_always = dut_val(dut_fn, fault_a, if0.drv_in1, if0.drv_in2);
    assign if1.dut_out        = dut_val(dut_fn, fault_c, if1.drv_in1, if1.drv_in2);
    assign if1.dut_out_always = dut_val(dut_fn, fault_a, if1.drv_in1, if1.drv_in2);

    logic       w_busy, w_done, w_pass;
    logic [1:0] w_drv, w_mask;
    logic [7:0] w_err;
    assign w_busy = cur ? if1.busy : if0.busy;
    assign w_done = cur ? if1.done : if0.done;
    assign w_pass = cur ? if1.pass : if0.pass;
    assign w_drv  = cur ? {if1.drv_in1, if1.drv_in2} : {if0.drv_in1, if0.drv_in2};
    assign w_mask = cur ? if1.err_mask : if0.err_mask;
    assign w_err  = cur ? {6'd0, if1.err_count} : if0.err_count;

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic set_start(input logic v);
        if (cur) if1.start = v;
        else     if0.start = v;
    endtask

    // One run on instance s. poke: extra start pulse mid-run. abort_c: cycle
    // at which reset is asserted (0 = never). hold: keep start high throughout.
    task automatic run(input logic s, input logic [1:0] op, input bit poke,
                       input int abort_c, input bit hold);
        int S, N, L, tot, mx;
        logic [1:0] mask;
        logic [7:0] exp_cnt;
        logic       exp_pass;
        logic [1:0] vb;
        logic e, m0, m1;
        cur = s;
        S   = s ? 1 : 2;
        N   = s ? 2 : 1;
        mx  = s ? 3 : 255;
        tot  = 0;
        mask = 2'b00;
        for (int p = 0; p < N; p++) begin
            for (int v = 0; v < 4; v++) begin
                vb = 2'(v);
                e  = gate_f(op, vb[1], vb[0]);
                m0 = dut_val(dut_fn, fault_c, vb[1], vb[0]) != e;
                m1 = dut_val(dut_fn, fault_a, vb[1], vb[0]) != e;
                tot += int'(m0) + int'(m1);
                mask |= {m1, m0};
            end
        end
        exp_cnt  = (tot > mx) ? 8'(mx) : 8'(tot);
        exp_pass = (mask == 2'b00);
        L = 1 + N * 4 * (S + 1);

        @(negedge clk);
        if0.op_sel = op;
        if1.op_sel = op;
        set_start(1'b1);
        @(posedge clk);
        for (int c = 1; c <= L + 2; c++) begin
            @(negedge clk);
            if (c == 1 && !hold) set_start(1'b0);
            if (c == 2) begin
                if0.op_sel = 2'($urandom);
                if1.op_sel = if0.op_sel;
            end
            if (poke && c == 5) set_start(1'b1);
            if (poke && c == 6) set_start(1'b0);
            if (c == abort_c) begin
                rst_n = 1'b0;
                #1;
                chk_eq("abort_outputs", {w_busy, w_done, w_pass, w_drv, w_mask, w_err}, 32'd0);
                for (int k = 0; k < 2; k++) begin
                    @(negedge clk);
                    chk_eq("abort_no_done", w_done, 1'b0);
                end
                rst_n = 1'b1;
                return;
            end
            if (c == 1) chk_eq("start_clears", {w_pass, w_mask, w_err}, 32'd0);
            if (c < L) begin
                vb = 2'(((c - 1) / (S + 1)) % 4);
                chk_eq("run_busy_done_drv", {w_busy, w_done, w_drv}, {1'b1, 1'b0, vb});
            end else if (c == L) begin
                chk_eq("finish_busy_done_drv", {w_busy, w_done, w_drv}, {1'b0, 1'b1, 2'b00});
                chk_eq("err_count", w_err, exp_cnt);
                chk_eq("err_mask", w_mask, mask);
                chk_eq("pass", w_pass, exp_pass);
            end else if (c == L + 1) begin
                chk_eq("idle_after_done", {w_busy, w_done, w_pass, w_err},
                       {1'b0, 1'b0, exp_pass, exp_cnt});
            end else begin
                chk_eq("retrigger_busy", w_busy, hold);
            end
        end
        if (hold) begin
            set_start(1'b0);
            for (int k = 0; k < 200 && !w_done; k++) @(negedge clk);
            chk_eq("retrigger_done", w_done, 1'b1);
            @(negedge clk);
        end
    endtask

    initial begin
        n_tests    = 0;
        n_fail     = 0;
        cur        = 1'b0;
        dut_fn     = 2'd0;
        fault_c    = 2'd0;
        fault_a    = 2'd0;
        rst_n      = 1'b0;
        if0.start  = 1'b0;
        if1.start  = 1'b0;
        if0.op_sel = 2'd0;
        if1.op_sel = 2'd0;
        repeat (3) @(negedge clk);
        chk_eq("reset_u0", {if0.busy, if0.done, if0.pass, if0.drv_in1, if0.drv_in2,
                            if0.err_mask, if0.err_count}, 32'd0);
        chk_eq("reset_u1", {if1.busy, if1.done, if1.pass, if1.drv_in1, if1.drv_in2,
                            if1.err_mask, if1.err_count}, 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        run(1'b0, 2'd0, 1'b0, 0, 1'b0);          // AND DUT, AND expected
        run(1'b0, 2'd1, 1'b0, 0, 1'b0);          // OR expected: 4 errors
        fault_a = 2'd1;
        run(1'b0, 2'd0, 1'b0, 0, 1'b0);          // always-output stuck-at-0
        run(1'b1, 2'd0, 1'b0, 0, 1'b0);
        fault_a = 2'd0;
        run(1'b1, 2'd3, 1'b0, 0, 1'b0);          // NAND: saturates at 3
        run(1'b0, 2'd0, 1'b1, 0, 1'b0);          // stray start mid-run
        run(1'b0, 2'd2, 1'b0, 9, 1'b0);          // reset in SAMPLE of vector 2
        run(1'b0, 2'd0, 1'b0, 0, 1'b0);          // normal run after abort
        run(1'b1, 2'd1, 1'b0, 0, 1'b1);          // start held high

        for (int i = 0; i < 12; i++) begin
            dut_fn  = 2'($urandom);
            fault_c = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'd0;
            fault_a = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'd0;
            run(1'($urandom), 2'($urandom), 1'($urandom), 0, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
